rob_multi_commit: RTL and testbench

Parametrised reorder buffer for the out-of-order core: accepts up to SS dispatched instructions per cycle and takes CDB_PORTS writeback completions per cycle. Retires 0..SS done entries per cycle strictly in program order, with partial commit (a ready prefix retires even if later entries are not done). Handles branch-mispredict recovery by flushing all younger entries. Sits between rename/dispatch and the RRAT/RVFI commit path.

---
 rtl/rob_multi_commit.sv | 196 +++++++++++++++++++
 tb/tb_rob_multi_commit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi_commit.sv
// Reorder buffer with multi-lane in-order commit.
//
// Dispatch writes up to SS entries per cycle at the tail. Writeback ports mark
// entries done, and may also mark them mispredicted with a corrected PC. Commit
// retires the longest done prefix starting at head, up to SS entries per cycle.
// It stops after a mispredicted entry, which retires and raises flush. Flush
// empties the buffer in that same edge.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   dispatch_*                 per-lane allocate request / ready / allocated IDs
//   cdb_*                      writeback completions (done, mispredict, target)
//   commit_*                   retiring lanes, payload and RVFI order
//   flush, flush_pc            mispredict redirect, coincident with its commit
//   rob_count, rob_empty       occupancy
module rob_multi_commit #(
    parameter int unsigned SS        = 2,
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned CDB_PORTS = 3,
    parameter int unsigned ARCH_W    = 5,
    parameter int unsigned PHYS_W    = 6,
    parameter int unsigned PC_W      = 32,
    localparam int unsigned ID_W     = $clog2(ROB_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SS-1:0]             dispatch_valid,
    input  logic [SS*ARCH_W-1:0]      dispatch_rd,
    input  logic [SS*PHYS_W-1:0]      dispatch_pd,
    input  logic [SS*PC_W-1:0]        dispatch_pc,
    output logic                      dispatch_ready,
    output logic [SS*ID_W-1:0]        dispatch_rob_id,
    input  logic [CDB_PORTS-1:0]      cdb_valid,
    input  logic [CDB_PORTS*ID_W-1:0] cdb_rob_id,
    input  logic [CDB_PORTS-1:0]      cdb_mispredict,
    input  logic [CDB_PORTS*PC_W-1:0] cdb_target,
    output logic [SS-1:0]             commit_valid,
    output logic [SS*ARCH_W-1:0]      commit_rd,
    output logic [SS*PHYS_W-1:0]      commit_pd,
    output logic [SS*PC_W-1:0]        commit_pc,
    output logic [SS*64-1:0]          commit_order,
    output logic                      flush,
    output logic [PC_W-1:0]           flush_pc,
    output logic [ID_W:0]             rob_count,
    output logic                      rob_empty
);

    logic [ID_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [ID_W:0]        count_q, count_d;
    logic [63:0]          order_q, order_d;
    logic [ROB_DEPTH-1:0] done_q, done_d, mp_q, mp_d;

    logic [ARCH_W-1:0]    rd_q     [ROB_DEPTH];
    logic [PHYS_W-1:0]    pd_q     [ROB_DEPTH];
    logic [PC_W-1:0]      pc_q     [ROB_DEPTH];
    logic [PC_W-1:0]      target_q [ROB_DEPTH];

    logic [ROB_DEPTH-1:0] occupied;
    logic [ID_W:0]        n_com, n_acc;

    // An entry is live when its distance from head is below the count.
    always_comb begin
        logic [ID_W-1:0] off;
        occupied = '0;
        off      = '0;
        for (int e = 0; e < ROB_DEPTH; e++) begin
            off         = ID_W'(e) - head_q;
            occupied[e] = {1'b0, off} < count_q;
        end
    end

    // Commit: the ready prefix from head. The chain breaks after a mispredict.
    always_comb begin
        logic            chain;
        logic [ID_W-1:0] idx;
        commit_valid = '0;
        commit_rd    = 'x;
        commit_pd    = 'x;
        commit_pc    = 'x;
        commit_order = '0;
        flush        = 1'b0;
        flush_pc     = '0;
        n_com        = '0;
        chain        = 1'b1;
        idx          = '0;
        for (int i = 0; i < SS; i++) begin
            idx = head_q + ID_W'(i);
            commit_order[i*64 +: 64] = order_q + 64'(i);
            if (chain && occupied[idx] && done_q[idx]) begin
                commit_valid[i]                = 1'b1;
                commit_rd[i*ARCH_W +: ARCH_W]  = rd_q[idx];
                commit_pd[i*PHYS_W +: PHYS_W]  = pd_q[idx];
                commit_pc[i*PC_W +: PC_W]      = pc_q[idx];
                n_com                          = n_com + 1'b1;
                if (mp_q[idx]) begin
                    flush    = 1'b1;
                    flush_pc = target_q[idx];
                    chain    = 1'b0;
                end
            end else begin
                chain = 1'b0;
            end
        end
    end

    // The registered count alone gates dispatch. Same-cycle commits free no space.
    assign dispatch_ready = (count_q <= (ID_W+1)'(ROB_DEPTH - SS)) && !flush;
    assign rob_count      = count_q;
    assign rob_empty      = (count_q == '0);

    always_comb begin
        for (int i = 0; i < SS; i++) begin
            dispatch_rob_id[i*ID_W +: ID_W] = tail_q + ID_W'(i);
        end
    end

    always_comb begin
        n_acc = '0;
        for (int i = 0; i < SS; i++) begin
            if (dispatch_ready && dispatch_valid[i]) begin
                n_acc = n_acc + 1'b1;
            end
        end
    end

    always_comb begin
        logic [ID_W-1:0] cid;
        cid     = '0;
        done_d  = done_q;
        mp_d    = mp_q;
        head_d  = head_q + n_com[ID_W-1:0];
        order_d = order_q + 64'(n_com);
        if (flush) begin
            tail_d  = head_d;
            count_d = '0;
            done_d  = '0;
            mp_d    = '0;
        end else begin
            tail_d  = tail_q + n_acc[ID_W-1:0];
            count_d = count_q + n_acc - n_com;
            for (int p = 0; p < CDB_PORTS; p++) begin
                cid = cdb_rob_id[p*ID_W +: ID_W];
                if (cdb_valid[p] && occupied[cid]) begin
                    done_d[cid] = 1'b1;
                    if (cdb_mispredict[p]) begin
                        mp_d[cid] = 1'b1;
                    end
                end
            end
            // Dispatch slots are never occupied, so no conflict with writeback.
            for (int i = 0; i < SS; i++) begin
                if (dispatch_ready && dispatch_valid[i]) begin
                    done_d[tail_q + ID_W'(i)] = 1'b0;
                    mp_d[tail_q + ID_W'(i)]   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            order_q <= '0;
            done_q  <= '0;
            mp_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            order_q <= order_d;
            done_q  <= done_d;
            mp_q    <= mp_d;
        end
    end

    // Payload storage needs no reset. The valid bits above guard every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SS; i++) begin
            if (dispatch_ready && dispatch_valid[i]) begin
                rd_q[tail_q + ID_W'(i)] <= dispatch_rd[i*ARCH_W +: ARCH_W];
                pd_q[tail_q + ID_W'(i)] <= dispatch_pd[i*PHYS_W +: PHYS_W];
                pc_q[tail_q + ID_W'(i)] <= dispatch_pc[i*PC_W +: PC_W];
            end
        end
        // Descending scan so the lowest-index mispredicting port lands last.
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (cdb_valid[p] && cdb_mispredict[p] && !flush &&
                occupied[cdb_rob_id[p*ID_W +: ID_W]]) begin
                target_q[cdb_rob_id[p*ID_W +: ID_W]] <= cdb_target[p*PC_W +: PC_W];
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_commit.sv
module tb_rob_multi_commit;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   dispatch_valid;
    logic [9:0]   dispatch_rd;
    logic [11:0]  dispatch_pd;
    logic [63:0]  dispatch_pc;
    logic         dispatch_ready;
    logic [7:0]   dispatch_rob_id;
    logic [2:0]   cdb_valid;
    logic [11:0]  cdb_rob_id;
    logic [2:0]   cdb_mispredict;
    logic [95:0]  cdb_target;
    logic [1:0]   commit_valid;
    logic [9:0]   commit_rd;
    logic [11:0]  commit_pd;
    logic [63:0]  commit_pc;
    logic [127:0] commit_order;
    logic         flush;
    logic [31:0]  flush_pc;
    logic [4:0]   rob_count;
    logic         rob_empty;

    int n_cmp = 0;
    int n_err = 0;

    rob_multi_commit dut (
        .clk             (clk),
        .rst             (rst),
        .dispatch_valid  (dispatch_valid),
        .dispatch_rd     (dispatch_rd),
        .dispatch_pd     (dispatch_pd),
        .dispatch_pc     (dispatch_pc),
        .dispatch_ready  (dispatch_ready),
        .dispatch_rob_id (dispatch_rob_id),
        .cdb_valid       (cdb_valid),
        .cdb_rob_id      (cdb_rob_id),
        .cdb_mispredict  (cdb_mispredict),
        .cdb_target      (cdb_target),
        .commit_valid    (commit_valid),
        .commit_rd       (commit_rd),
        .commit_pd       (commit_pd),
        .commit_pc       (commit_pc),
        .commit_order    (commit_order),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .rob_count       (rob_count),
        .rob_empty       (rob_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_valid = '0;
        dispatch_rd    = '0;
        dispatch_pd    = '0;
        dispatch_pc    = '0;
        cdb_valid      = '0;
        cdb_rob_id     = '0;
        cdb_mispredict = '0;
        cdb_target     = '0;
    endtask

    // rd and pd come from PC bits, so the commit payload can be cross-checked.
    task automatic disp(input logic [1:0] v, input logic [31:0] pc0);
        logic [31:0] pc1;
        pc1            = pc0 + 32'd4;
        dispatch_valid = v;
        dispatch_pc    = {pc1, pc0};
        dispatch_rd    = {pc1[6:2], pc0[6:2]};
        dispatch_pd    = {pc1[7:2], pc0[7:2]};
    endtask

    task automatic cdb(input int p, input logic [3:0] id, input logic mp, input logic [31:0] tgt);
        cdb_valid[p]          = 1'b1;
        cdb_rob_id[p*4 +: 4]  = id;
        cdb_mispredict[p]     = mp;
        cdb_target[p*32 +: 32] = tgt;
    endtask

    initial begin
        int          sent, retired, cyc, k, n;
        int          inflight[$];
        logic [31:0] exp_pc[$];
        logic [63:0] exp_ord;
        logic [3:0]  mtail;

        // Reset values
        rst = 1'b0;
        idle();
        #2;
        check("rst_count", rob_count, 0);
        check("rst_empty", rob_empty, 1);
        check("rst_ready", dispatch_ready, 1);
        check("rst_commit", commit_valid, 0);
        check("rst_flush", flush, 0);
        tick();
        rst = 1'b1;

        // Fill: IDs 0..15 in order, full at 16
        for (int i = 0; i < 8; i++) begin
            check("fill_ready", dispatch_ready, 1);
            check("fill_id", dispatch_rob_id, {4'(2*i+1), 4'(2*i)});
            disp(2'b11, 32'h100 + 32'(8*i));
            tick();
        end
        check("full_count", rob_count, 16);
        check("full_ready", dispatch_ready, 0);
        tick();
        check("full_drop", rob_count, 16);
        idle();
        rst = 1'b0;
        #1;
        check("rst2_count", rob_count, 0);
        #1;
        rst = 1'b1;
        tick();

        // In-order commit: ID1 done first, then ID0
        disp(2'b11, 32'h100);
        tick();
        disp(2'b11, 32'h108);
        tick();
        idle();
        cdb(0, 4'd1, 1'b0, 32'h0);
        tick();
        idle();
        check("ooo_hold", commit_valid, 2'b00);
        cdb(2, 4'd0, 1'b0, 32'h0);
        #1;
        check("no_bypass", commit_valid, 2'b00);
        tick();
        idle();
        check("dual_valid", commit_valid, 2'b11);
        check("dual_order", commit_order, {64'd1, 64'd0});
        check("dual_pc", commit_pc, {32'h104, 32'h100});
        check("dual_rd", commit_rd, {5'h01, 5'h00});
        tick();
        check("dual_count", rob_count, 2);
        check("dual_tail", dispatch_rob_id, {4'd5, 4'd4});

        // Partial commit
        cdb(1, 4'd2, 1'b0, 32'h0);
        tick();
        idle();
        check("part_valid", commit_valid, 2'b01);
        check("part_order", commit_order[63:0], 2);
        check("part_pc", commit_pc[31:0], 32'h108);
        tick();
        check("part_wait", commit_valid, 2'b00);
        check("part_count", rob_count, 1);
        cdb(0, 4'd3, 1'b0, 32'h0);
        tick();
        idle();
        check("part2_valid", commit_valid, 2'b01);
        check("part2_order", commit_order[63:0], 3);
        tick();
        check("part2_empty", rob_empty, 1);

        // Mispredict at ID5 with IDs 5..9 occupied
        disp(2'b01, 32'h110);
        tick();
        idle();
        cdb(0, 4'd4, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        check("mp_tail", dispatch_rob_id[3:0], 5);
        disp(2'b11, 32'h200);
        tick();
        disp(2'b11, 32'h208);
        tick();
        disp(2'b01, 32'h210);
        tick();
        idle();
        check("mp_count", rob_count, 5);
        cdb(0, 4'd6, 1'b0, 32'h0);
        cdb(1, 4'd5, 1'b1, 32'h8000_0040);
        cdb(2, 4'd5, 1'b1, 32'hdead_0000);
        tick();
        idle();
        check("mp_valid", commit_valid, 2'b01);
        check("mp_flush", flush, 1);
        check("mp_flush_pc", flush_pc, 32'h8000_0040);
        check("mp_ready", dispatch_ready, 0);
        check("mp_order", commit_order[63:0], 5);
        check("mp_pc", commit_pc[31:0], 32'h200);
        disp(2'b11, 32'h500);
        cdb(0, 4'd7, 1'b0, 32'h0);
        tick();
        idle();
        check("post_flush_count", rob_count, 0);
        check("post_flush_empty", rob_empty, 1);
        check("post_flush_flag", flush, 0);
        check("post_flush_tail", dispatch_rob_id, {4'd7, 4'd6});
        disp(2'b11, 32'h220);
        tick();
        idle();
        tick();
        check("post_flush_idle", commit_valid, 2'b00);
        cdb(0, 4'd6, 1'b0, 32'h0);
        cdb(1, 4'd7, 1'b0, 32'h0);
        tick();
        idle();
        check("post_flush_commit", commit_valid, 2'b11);
        check("post_flush_order", commit_order, {64'd7, 64'd6});
        tick();

        // Wrap: 40 instructions, random completion order
        sent    = 0;
        retired = 0;
        cyc     = 0;
        exp_ord = 64'd8;
        mtail   = 4'd8;
        while (cyc < 600 && retired < 40) begin
            for (int l = 0; l < 2; l++) begin
                if (commit_valid[l]) begin
                    check("wrap_order", commit_order[l*64 +: 64], exp_ord);
                    if (exp_pc.size() > 0) begin
                        check("wrap_pc", commit_pc[l*32 +: 32], exp_pc.pop_front());
                    end else begin
                        check("wrap_spurious", exp_pc.size(), 1);
                    end
                    exp_ord++;
                    retired++;
                end
            end
            idle();
            for (int p = 0; p < 3; p++) begin
                if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                    k = $urandom_range(0, inflight.size() - 1);
                    cdb(p, 4'(inflight[k]), 1'b0, 32'h0);
                    inflight.delete(k);
                end
            end
            if (dispatch_ready && sent < 40) begin
                n = (40 - sent >= 2) ? 2 : 1;
                check("wrap_id", dispatch_rob_id[3:0], mtail);
                disp((n == 2) ? 2'b11 : 2'b01, 32'h1000 + 32'(4*sent));
                for (int j = 0; j < n; j++) begin
                    exp_pc.push_back(32'h1000 + 32'(4*(sent+j)));
                    inflight.push_back(int'(mtail + 4'(j)));
                end
                mtail = mtail + 4'(n);
                sent  = sent + n;
            end
            tick();
            cyc++;
        end
        idle();
        check("wrap_retired", retired, 40);
        check("wrap_drained", rob_count, 0);

        // Reset mid-stream with 7 entries and CDB active
        disp(2'b11, 32'h300);
        tick();
        disp(2'b11, 32'h308);
        tick();
        disp(2'b11, 32'h310);
        tick();
        disp(2'b01, 32'h318);
        tick();
        idle();
        cdb(0, 4'd0, 1'b0, 32'h0);
        cdb(1, 4'd1, 1'b0, 32'h0);
        tick();
        idle();
        cdb(2, 4'd3, 1'b1, 32'h4444_0000);
        check("mid_count", rob_count, 7);
        check("mid_commit", commit_valid, 2'b11);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_count", rob_count, 0);
        check("mid_rst_empty", rob_empty, 1);
        check("mid_rst_commit", commit_valid, 2'b00);
        check("mid_rst_flush", flush, 0);
        check("mid_rst_ready", dispatch_ready, 1);
        tick();
        rst = 1'b1;
        idle();
        check("restart_id", dispatch_rob_id, {4'd1, 4'd0});
        disp(2'b11, 32'h400);
        tick();
        idle();
        tick();
        check("restart_idle", commit_valid, 2'b00);
        cdb(0, 4'd0, 1'b0, 32'h0);
        cdb(1, 4'd1, 1'b0, 32'h0);
        tick();
        idle();
        check("restart_commit", commit_valid, 2'b11);
        check("restart_order", commit_order, {64'd1, 64'd0});
        check("restart_pc", commit_pc, {32'h404, 32'h400});
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
